// File: rtl/param_stack_cpu_if.sv
// Host/lab-side bus of param_stack_cpu: run control, IMEM loader, I/O word and status.
//   master : host/loader side (drives start, prog_*, data_in; observes status)
//   slave  : processor side
interface param_stack_cpu_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 5
);
  logic              start;
  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [DATA_W+3:0] prog_data;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              busy;
  logic              halted;
  logic              fault;
  logic [1:0]        fault_code;
  logic [PC_W-1:0]   pc;

  modport master (
    output start, prog_we, prog_addr, prog_data, data_in,
    input  data_out, out_valid, busy, halted, fault, fault_code, pc
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, data_in,
    output data_out, out_valid, busy, halted, fault, fault_code, pc
  );
endinterface

// File: rtl/param_stack_cpu.sv
// Parametrised stack processor, one instruction per clock.
// Ports:
//   clk  : single clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : param_stack_cpu_if.slave -- start, IMEM loader (prog_we/addr/data),
//          data_in (IN_ADDR read), data_out/out_valid (OUT_ADDR write),
//          busy/halted/fault/fault_code status and current pc.
// IMEM and DMEM are not cleared by reset. DMEM word IN_ADDR reads as data_in,
// DMEM word OUT_ADDR also drives data_out when POPped to.
module param_stack_cpu #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int PC_W    = 5,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  param_stack_cpu_if.slave   bus
);
  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int IW    = 4 + DATA_W;
  localparam logic [DMEM_AW-1:0] OUT_ADDR = '1;
  localparam logic [DMEM_AW-1:0] IN_ADDR  = OUT_ADDR - DMEM_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;
  typedef enum logic [3:0] {
    OP_PUSHC = 4'd0, OP_PUSH = 4'd1, OP_POP = 4'd2, OP_JUMP = 4'd3,
    OP_JZ    = 4'd4, OP_JS   = 4'd5, OP_ADD = 4'd6, OP_SUB  = 4'd7,
    OP_DUP   = 4'd8, OP_SWAP = 4'd9, OP_HALT = 4'd15
  } op_t;

  logic [IW-1:0]     imem [2**PC_W];
  logic [DATA_W-1:0] dmem [2**DMEM_AW];
  logic [DATA_W-1:0] stk  [DEPTH];

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_q, pc_nxt;
  logic [SP_W-1:0]   sp, sp_nxt;
  logic              zero, zero_nxt, sign, sign_nxt;
  logic [DATA_W-1:0] dout_q, dout_nxt;
  logic              ov_q, ov_nxt;
  logic [1:0]        code_q, code_nxt;

  logic [IW-1:0]      instr;
  logic [3:0]         opcode;
  logic [DATA_W-1:0]  v, t_val, n_val, res, rd_val;
  logic [DMEM_AW-1:0] addr;
  logic [SP_W-1:0]    sp_m1, sp_p1, need;
  logic [IDX_W-1:0]   sp_idx, t_idx, n_idx;
  logic [PC_W-1:0]    pc_inc;
  logic               grow, illegal;
  logic [1:0]         chk_code;

  logic               wa_en, wb_en, dm_we;
  logic [IDX_W-1:0]   wa_idx, wb_idx;
  logic [DATA_W-1:0]  wa_data, wb_data;

  assign instr  = imem[pc_q];
  assign opcode = instr[IW-1 -: 4];
  assign v      = instr[DATA_W-1:0];
  assign addr   = v[DMEM_AW-1:0];
  assign sp_m1  = sp - SP_W'(1);
  assign sp_p1  = sp + SP_W'(1);
  assign sp_idx = sp[IDX_W-1:0];
  assign t_idx  = sp_m1[IDX_W-1:0];
  assign n_idx  = t_idx - IDX_W'(1);
  assign t_val  = stk[t_idx];
  assign n_val  = stk[n_idx];
  assign pc_inc = pc_q + PC_W'(1);
  assign res    = (opcode == OP_ADD) ? n_val + t_val : n_val - t_val;
  assign rd_val = (addr == IN_ADDR) ? bus.data_in : dmem[addr];

  // Operand/space requirement per opcode; priority illegal > underflow > overflow.
  always_comb begin
    need    = '0;
    grow    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_PUSHC, OP_PUSH:             grow = 1'b1;
      OP_POP, OP_JUMP, OP_JZ, OP_JS: need = SP_W'(1);
      OP_DUP:                        begin need = SP_W'(1); grow = 1'b1; end
      OP_ADD, OP_SUB, OP_SWAP:       need = SP_W'(2);
      OP_HALT:                       ;
      default:                       illegal = 1'b1;
    endcase
    if (illegal)                                chk_code = 2'd3;
    else if (sp < need)                         chk_code = 2'd2;
    else if (grow && (sp == SP_W'(DEPTH)))      chk_code = 2'd1;
    else                                        chk_code = 2'd0;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    sp_nxt    = sp;
    zero_nxt  = zero;
    sign_nxt  = sign;
    dout_nxt  = dout_q;
    ov_nxt    = 1'b0;
    code_nxt  = code_q;
    wa_en     = 1'b0;
    wa_idx    = sp_idx;
    wa_data   = v;
    wb_en     = 1'b0;
    wb_idx    = n_idx;
    wb_data   = t_val;
    dm_we     = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_RUN;
      S_RUN: begin
        if (chk_code != 2'd0) begin
          // faulting instruction leaves pc, stack, flags and memories untouched
          state_nxt = S_FAULT;
          code_nxt  = chk_code;
        end else begin
          pc_nxt = pc_inc;
          case (opcode)
            OP_PUSHC: begin wa_en = 1'b1; sp_nxt = sp_p1; end
            OP_PUSH:  begin wa_en = 1'b1; wa_data = rd_val; sp_nxt = sp_p1; end
            OP_POP: begin
              dm_we  = 1'b1;
              sp_nxt = sp_m1;
              if (addr == OUT_ADDR) begin
                dout_nxt = t_val;
                ov_nxt   = 1'b1;
              end
            end
            OP_JUMP: begin sp_nxt = sp_m1; pc_nxt = t_val[PC_W-1:0]; end
            OP_JZ: begin
              sp_nxt = sp_m1;
              if (zero) pc_nxt = t_val[PC_W-1:0];
            end
            OP_JS: begin
              sp_nxt = sp_m1;
              if (sign) pc_nxt = t_val[PC_W-1:0];
            end
            OP_ADD, OP_SUB: begin
              wa_en    = 1'b1;
              wa_idx   = n_idx;
              wa_data  = res;
              sp_nxt   = sp_m1;
              zero_nxt = (res == '0);
              sign_nxt = res[DATA_W-1];
            end
            OP_DUP:  begin wa_en = 1'b1; wa_data = t_val; sp_nxt = sp_p1; end
            OP_SWAP: begin
              wa_en   = 1'b1;
              wa_idx  = t_idx;
              wa_data = n_val;
              wb_en   = 1'b1;
            end
            OP_HALT: begin state_nxt = S_HALT; pc_nxt = pc_q; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc_q   <= '0;
      sp     <= '0;
      zero   <= 1'b0;
      sign   <= 1'b0;
      dout_q <= '0;
      ov_q   <= 1'b0;
      code_q <= 2'd0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      sp     <= sp_nxt;
      zero   <= zero_nxt;
      sign   <= sign_nxt;
      dout_q <= dout_nxt;
      ov_q   <= ov_nxt;
      code_q <= code_nxt;
    end
  end

  // Memories are not reset; rst only suppresses the in-flight instruction's writes.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state != S_RUN)) imem[bus.prog_addr] <= bus.prog_data;
    if (!rst) begin
      if (wa_en) stk[wa_idx] <= wa_data;
      if (wb_en) stk[wb_idx] <= wb_data;
      if (dm_we) dmem[addr]  <= t_val;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.out_valid  = ov_q;
  assign bus.busy       = (state == S_RUN);
  assign bus.halted     = (state == S_HALT);
  assign bus.fault      = (state == S_FAULT);
  assign bus.fault_code = code_q;
  assign bus.pc         = pc_q;
endmodule

// File: tb/tb_param_stack_cpu.sv
module tb_param_stack_cpu;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int PC_W    = 5;
  localparam int DMEM_AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_stack_cpu_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  param_stack_cpu #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural state only, stack kept as a queue.
  typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mst_t;
  mst_t       m_state;
  int         m_pc;
  logic [7:0] m_stk[$];
  bit         m_z, m_s;
  logic [7:0] m_dmem [256];
  logic [11:0] m_imem [32];
  int         m_dout, m_ov, m_code;

  logic [11:0] prog [32];
  int          ov_seen;

  task automatic m_fault(input int code);
    m_state = M_FAULT;
    m_code  = code;
  endtask

  task automatic model_step(input bit r, input bit st, input bit we, input int wa,
                            input logic [11:0] wd, input logic [7:0] din);
    logic [11:0] ins;
    int op, need;
    bit grows;
    logic [7:0] v, t, n, res;
    if (we && m_state != M_RUN) m_imem[wa] = wd;
    m_ov = 0;
    if (r) begin
      m_state = M_IDLE; m_pc = 0; m_stk.delete(); m_z = 0; m_s = 0;
      m_dout = 0; m_code = 0;
      return;
    end
    case (m_state)
      M_IDLE: if (st) m_state = M_RUN;
      M_RUN: begin
        ins = m_imem[m_pc];
        op  = int'(ins[11:8]);
        v   = ins[7:0];
        need  = (op inside {2, 3, 4, 5, 8}) ? 1 : (op inside {6, 7, 9}) ? 2 : 0;
        grows = op inside {0, 1, 8};
        if (op inside {[10:14]})                 m_fault(3);
        else if (m_stk.size() < need)            m_fault(2);
        else if (grows && m_stk.size() == DEPTH) m_fault(1);
        else begin
          m_pc = (m_pc + 1) % 32;
          case (op)
            0: m_stk.push_back(v);
            1: m_stk.push_back(v == 8'hFE ? din : m_dmem[v]);
            2: begin
              t = m_stk.pop_back();
              m_dmem[v] = t;
              if (v == 8'hFF) begin m_dout = t; m_ov = 1; end
            end
            3: begin t = m_stk.pop_back(); m_pc = t % 32; end
            4: begin t = m_stk.pop_back(); if (m_z) m_pc = t % 32; end
            5: begin t = m_stk.pop_back(); if (m_s) m_pc = t % 32; end
            6, 7: begin
              t = m_stk.pop_back();
              n = m_stk.pop_back();
              res = (op == 6) ? n + t : n - t;
              m_stk.push_back(res);
              m_z = (res == 0);
              m_s = res[7];
            end
            8: m_stk.push_back(m_stk[$]);
            9: begin
              t = m_stk.pop_back();
              n = m_stk.pop_back();
              m_stk.push_back(t);
              m_stk.push_back(n);
            end
            15: begin m_state = M_HALT; m_pc = (m_pc + 31) % 32; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input bit r, input bit st, input bit we, input int wa,
                     input logic [11:0] wd, input logic [7:0] din);
    logic [4:0] a;
    a = wa[4:0];
    rst = r; bus.start = st; bus.prog_we = we; bus.prog_addr = a;
    bus.prog_data = wd; bus.data_in = din;
    @(posedge clk);
    model_step(r, st, we, wa, wd, din);
    #1;
    check("pc", 32'(bus.pc), 32'(m_pc));
    check("state", {29'd0, bus.busy, bus.halted, bus.fault},
          {29'd0, m_state == M_RUN, m_state == M_HALT, m_state == M_FAULT});
    check("fault_code", 32'(bus.fault_code), 32'(m_code));
    check("data_out", 32'(bus.data_out), 32'(m_dout));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (bus.out_valid === 1'b1) ov_seen++;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 12'h0, 8'h00);
  endtask

  task automatic fill_prog();
    for (int i = 0; i < 32; i++) prog[i] = 12'hA00;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, i, prog[i], 8'h00);
  endtask

  task automatic do_start(input logic [7:0] din);
    cyc(0, 1, 0, 0, 12'h0, din);
  endtask

  // din < 0 selects a fresh random data_in each cycle; stray IMEM writes exercise the RUN lockout.
  task automatic run(input int n, input int din);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (din < 0) ? 8'($urandom) : 8'(din);
      cyc(0, 0, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 31)),
          12'($urandom), d);
    end
  endtask

  function automatic logic [11:0] rand_instr();
    int r;
    logic [7:0] a;
    int pick;
    r = $urandom_range(0, 99);
    pick = $urandom_range(0, 4);
    a = (pick == 4) ? 8'hFE : 8'(8'h10 + pick);
    if (r < 30)      return {4'd0, 8'($urandom)};
    else if (r < 40) return {4'd1, a};
    else if (r < 52) return {4'd2, ($urandom_range(0, 3) == 0) ? 8'hFF : a};
    else if (r < 56) return 12'h300;
    else if (r < 62) return 12'h400;
    else if (r < 68) return 12'h500;
    else if (r < 78) return 12'h600;
    else if (r < 86) return 12'h700;
    else if (r < 92) return 12'h800;
    else if (r < 97) return 12'h900;
    else if (r < 98) return {4'($urandom_range(10, 14)), 8'h00};
    else             return 12'hF00;
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0;
    bus.prog_data = '0; bus.data_in = '0;
    ov_seen = 0;
    do_reset();

    // Preload DMEM words used by random PUSHes, then read one back right after its write.
    fill_prog();
    prog[0] = 12'h011; prog[1] = 12'h210;
    prog[2] = 12'h080; prog[3] = 12'h211;
    prog[4] = 12'h000; prog[5] = 12'h212;
    prog[6] = 12'h07F; prog[7] = 12'h213;
    prog[8] = 12'h113; prog[9] = 12'h2FF; prog[10] = 12'hF00;
    load_prog(); do_start(8'h00); run(14, 0);
    check("wr_rd_dout", 32'(bus.data_out), 32'h7F);

    // 5 - 3 to OUT, single out_valid pulse
    do_reset(); fill_prog();
    prog[0] = 12'h005; prog[1] = 12'h003; prog[2] = 12'h700;
    prog[3] = 12'h2FF; prog[4] = 12'hF00;
    load_prog(); do_start(8'h00);
    ov_seen = 0;
    run(8, 0);
    check("sub_dout", 32'(bus.data_out), 32'd2);
    check("sub_ov_pulses", 32'(ov_seen), 32'd1);
    check("sub_halted", 32'(bus.halted), 32'd1);

    // JZ taken on ZERO from 3-3
    do_reset(); fill_prog();
    prog[0] = 12'h003; prog[1] = 12'h003; prog[2] = 12'h700;
    prog[3] = 12'h009; prog[4] = 12'h400; prog[9] = 12'hF00;
    load_prog(); do_start(8'h00); run(8, 0);
    check("jz_pc", 32'(bus.pc), 32'd9);
    check("jz_halted", 32'(bus.halted), 32'd1);

    // SIGN set by 1-2, then cleared by 1+1 (JS not taken)
    do_reset(); fill_prog();
    prog[0] = 12'h001; prog[1] = 12'h002; prog[2] = 12'h700;
    prog[3] = 12'h008; prog[4] = 12'h500;
    prog[8] = 12'h001; prog[9] = 12'h001; prog[10] = 12'h600;
    prog[11] = 12'h00F; prog[12] = 12'h500; prog[13] = 12'hF00;
    load_prog(); do_start(8'h00); run(14, 0);
    check("js_pc", 32'(bus.pc), 32'd13);
    check("js_halted", 32'(bus.halted), 32'd1);

    // DEPTH+1 pushes -> overflow at the last push
    do_reset(); fill_prog();
    for (int i = 0; i <= DEPTH; i++) prog[i] = 12'(12'h040 + i);
    load_prog(); do_start(8'h00); run(DEPTH + 4, 0);
    check("ovf_code", 32'(bus.fault_code), 32'd1);
    check("ovf_pc", 32'(bus.pc), 32'(DEPTH));

    // ADD with one operand -> underflow
    do_reset(); fill_prog();
    prog[0] = 12'h001; prog[1] = 12'h600;
    load_prog(); do_start(8'h00); run(4, 0);
    check("unf_code", 32'(bus.fault_code), 32'd2);
    check("unf_pc", 32'(bus.pc), 32'd1);

    // Illegal opcode 12, then reset + start restarts at pc 0
    do_reset(); fill_prog();
    prog[0] = 12'hC00;
    load_prog(); do_start(8'h00); run(3, 0);
    check("ill_code", 32'(bus.fault_code), 32'd3);
    do_reset(); do_start(8'h00);
    check("restart_pc", 32'(bus.pc), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);

    // prog_we together with start: HALT written at 0 is what runs
    do_reset();
    cyc(0, 1, 1, 0, 12'hF00, 8'h00);
    run(2, 0);
    check("we_start_halted", 32'(bus.halted), 32'd1);
    check("we_start_pc", 32'(bus.pc), 32'd0);

    // data_in through IN_ADDR to OUT_ADDR, then reset mid-loop
    do_reset(); fill_prog();
    prog[0] = 12'h1FE; prog[1] = 12'h2FF; prog[2] = 12'h002; prog[3] = 12'h300;
    load_prog(); do_start(8'h7A); run(7, 8'h7A);
    check("io_dout", 32'(bus.data_out), 32'h7A);
    check("io_busy", 32'(bus.busy), 32'd1);
    do_reset();
    check("io_dout_rst", 32'(bus.data_out), 32'd0);

    // Random programs against the model, including resets mid-run
    for (int p = 0; p < 40; p++) begin
      do_reset();
      for (int i = 0; i < 32; i++) prog[i] = rand_instr();
      load_prog();
      do_start(8'($urandom));
      run(int'($urandom_range(10, 60)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
